flex_counter_bank: RTL and testbench

Bank of NUM_CHANNELS independent, parametrised-width counters for the packet processor. Each channel counts up or down, wraps or saturates against a programmable terminal value, and can be parallel-loaded. Any channel above 0 can be cascaded so that it advances only on its lower neighbour's wrap, forming wide or prescaled counts (byte/word/packet counters, timeout timers). It replaces single-channel counter instances wherever a mode beyond plain up-count is needed.

---
 rtl/flex_counter_bank_if.sv | 39 +++
 rtl/flex_counter_bank.sv | 92 +++++++++
 tb/tb_flex_counter_bank.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/flex_counter_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : flex_counter_bank_if
//  Description : Control/status bundle for flex_counter_bank. Per-channel
//                single-bit controls use bit i; multi-bit fields are packed
//                as channel i at [i*NUM_CNT_BITS +: NUM_CNT_BITS].
//  Revision    : 1.0 - initial release
// ============================================================================
interface flex_counter_bank_if #(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_CHANNELS = 2
);
    logic [NUM_CHANNELS-1:0]              clear;
    logic [NUM_CHANNELS-1:0]              count_enable;
    logic [NUM_CHANNELS-1:0]              count_down;
    logic [NUM_CHANNELS-1:0]              saturate;
    logic [NUM_CHANNELS-1:0]              cascade;
    logic [NUM_CHANNELS-1:0]              load;
    logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] load_val;
    logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] rollover_val;
    logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] count_out;
    logic [NUM_CHANNELS-1:0]              rollover_flag;
    logic [NUM_CHANNELS-1:0]              wrap_pulse;

    // Controller side: drives controls, observes counts and flags
    modport master (
        output clear, count_enable, count_down, saturate, cascade, load,
               load_val, rollover_val,
        input  count_out, rollover_flag, wrap_pulse
    );

    // Counter bank side
    modport slave (
        input  clear, count_enable, count_down, saturate, cascade, load,
               load_val, rollover_val,
        output count_out, rollover_flag, wrap_pulse
    );
endinterface
`default_nettype wire

// File: rtl/flex_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : flex_counter_bank
//  Description : Bank of independent up/down counters with wrap or saturate
//                against a programmable terminal value, parallel load and
//                optional cascading on the lower neighbour's wrap event.
//  Revision    : 1.0 - initial release
// ============================================================================
module flex_counter_bank #(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_CHANNELS = 2
) (
    input  logic                clk,
    input  logic                n_rst,
    flex_counter_bank_if.slave  bus
);

    logic [NUM_CHANNELS-1:0][NUM_CNT_BITS-1:0] r_count;
    logic [NUM_CHANNELS-1:0]                   r_wrap_pulse;

    logic [NUM_CHANNELS-1:0][NUM_CNT_BITS-1:0] w_count_next;
    logic [NUM_CHANNELS-1:0][NUM_CNT_BITS-1:0] w_roll;
    logic [NUM_CHANNELS-1:0][NUM_CNT_BITS-1:0] w_load_val;
    logic [NUM_CHANNELS-1:0]                   w_step_req;
    logic [NUM_CHANNELS-1:0]                   w_past_term;
    logic [NUM_CHANNELS-1:0]                   w_wrap_evt;
    logic                                      w_chain;

    // Unpack the flattened buses and drive the per-channel outputs
    generate
        for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
            assign w_roll[g]     = bus.rollover_val[g*NUM_CNT_BITS +: NUM_CNT_BITS];
            assign w_load_val[g] = bus.load_val[g*NUM_CNT_BITS +: NUM_CNT_BITS];
            assign bus.count_out[g*NUM_CNT_BITS +: NUM_CNT_BITS] = r_count[g];
            assign bus.wrap_pulse[g] = r_wrap_pulse[g];
            // Terminal is the rollover value when counting up, zero when down
            assign bus.rollover_flag[g] =
                (r_count[g] == (bus.count_down[g] ? '0 : w_roll[g]));
        end
    endgenerate

    // Ripple the wrap-event chain upward and form each channel's next count.
    // The chain is the critical path: a cascaded channel may only step when
    // the channel below actually wraps on this same edge.
    always_comb begin
        w_step_req   = '0;
        w_past_term  = '0;
        w_wrap_evt   = '0;
        w_count_next = r_count;
        w_chain      = 1'b1;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_step_req[i]  = bus.count_enable[i] &
                             ((i == 0) | ~bus.cascade[i] | w_chain);
            // Counting up treats anything at or above the terminal as done,
            // so a loaded value beyond rollover_val still wraps cleanly
            w_past_term[i] = bus.count_down[i] ? (r_count[i] == '0)
                                               : (r_count[i] >= w_roll[i]);
            w_wrap_evt[i]  = w_step_req[i] & ~bus.saturate[i] & ~bus.clear[i] &
                             ~bus.load[i] & n_rst & w_past_term[i];
            w_chain        = w_wrap_evt[i];

            if (bus.clear[i]) begin
                w_count_next[i] = '0;
            end else if (bus.load[i]) begin
                w_count_next[i] = w_load_val[i];
            end else if (w_step_req[i]) begin
                if (w_past_term[i]) begin
                    if (!bus.saturate[i]) begin
                        w_count_next[i] = bus.count_down[i] ? w_roll[i] : '0;
                    end
                end else if (bus.count_down[i]) begin
                    w_count_next[i] = r_count[i] - 1'b1;
                end else begin
                    w_count_next[i] = r_count[i] + 1'b1;
                end
            end
        end
    end

    // Count and wrap-pulse registers; reset overrides everything
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_count      <= '0;
            r_wrap_pulse <= '0;
        end else begin
            r_count      <= w_count_next;
            r_wrap_pulse <= w_wrap_evt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flex_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flex_counter_bank
//  Description : Self-checking bench for flex_counter_bank. Directed cases
//                from the behaviour description followed by random traffic,
//                all compared against a per-channel arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flex_counter_bank;

    localparam int W = 4;
    localparam int N = 3;

    logic clk;
    logic n_rst;

    flex_counter_bank_if #(.NUM_CNT_BITS(W), .NUM_CHANNELS(N)) bus ();

    flex_counter_bank #(.NUM_CNT_BITS(W), .NUM_CHANNELS(N)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state: plain integer count and last wrap event per channel
    int unsigned m_cnt [N];
    bit          m_wp  [N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned roll_of(input int i);
        logic [N*W-1:0] v;
        v = bus.rollover_val;
        return int'(v[i*W +: W]);
    endfunction

    function automatic int unsigned lval_of(input int i);
        logic [N*W-1:0] v;
        v = bus.load_val;
        return int'(v[i*W +: W]);
    endfunction

    function automatic int unsigned cnt_of(input int i);
        logic [N*W-1:0] v;
        v = bus.count_out;
        return int'(v[i*W +: W]);
    endfunction

    // One step of a single counter in plain arithmetic; reports whether it wrapped
    function automatic int unsigned advance(input int unsigned c, input int unsigned rv,
                                            input bit down, input bit sat, output bit wrapped);
        wrapped = 1'b0;
        if (down) begin
            if (c != 0) return c - 1;
            wrapped = !sat;
            return sat ? 0 : rv;
        end
        if (c < rv) return c + 1;
        wrapped = !sat;
        return sat ? c : 0;
    endfunction

    task automatic check_all();
        int unsigned term;
        for (int i = 0; i < N; i++) begin
            term = bus.count_down[i] ? 0 : roll_of(i);
            check($sformatf("count%0d", i), cnt_of(i), m_cnt[i]);
            check($sformatf("wrap%0d", i), int'(bus.wrap_pulse[i]), int'(m_wp[i]));
            check($sformatf("flag%0d", i), int'(bus.rollover_flag[i]), int'(m_cnt[i] == term));
        end
    endtask

    // Predict the next state from the inputs currently applied, clock once, compare
    task automatic tick();
        int unsigned nxt [N];
        bit          evt [N];
        bit          lower_wrapped;
        bit          wrapped;
        bit          moves;
        lower_wrapped = 1'b0;
        for (int i = 0; i < N; i++) begin
            moves = bus.count_enable[i] && ((i == 0) || !bus.cascade[i] || lower_wrapped);
            evt[i] = 1'b0;
            nxt[i] = m_cnt[i];
            if (!n_rst || bus.clear[i]) begin
                nxt[i] = 0;
            end else if (bus.load[i]) begin
                nxt[i] = lval_of(i);
            end else if (moves) begin
                nxt[i] = advance(m_cnt[i], roll_of(i), bus.count_down[i], bus.saturate[i], wrapped);
                evt[i] = wrapped;
            end
            lower_wrapped = evt[i];
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = nxt[i];
            m_wp[i]  = evt[i];
        end
        #1;
        check_all();
    endtask

    task automatic set_roll(input int i, input int unsigned v);
        bus.rollover_val[i*W +: W] = W'(v);
    endtask

    task automatic set_lval(input int i, input int unsigned v);
        bus.load_val[i*W +: W] = W'(v);
    endtask

    initial begin
        int up_seq [7];
        int dn_seq [5];
        int wp1_count;
        up_seq = '{1, 2, 3, 4, 5, 0, 1};
        dn_seq = '{2, 1, 0, 0, 0};

        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_wp[i]  = 1'b0;
        end
        n_rst = 1'b0;
        bus.clear = '0; bus.count_enable = '0; bus.count_down = '0;
        bus.saturate = '0; bus.cascade = '0; bus.load = '0;
        bus.load_val = '0; bus.rollover_val = '0;
        #2;
        tick();
        tick();
        n_rst = 1'b1;

        // Up-count wrapping at 5
        set_roll(0, 5);
        bus.count_enable = 3'b001;
        for (int k = 0; k < 7; k++) begin
            tick();
            check("upwrap_seq", cnt_of(0), up_seq[k]);
            check("upwrap_flag", int'(bus.rollover_flag[0]), int'(k == 4));
            check("upwrap_pulse", int'(bus.wrap_pulse[0]), int'(k == 5));
        end

        // Reset lowered between edges is ignored until the next edge
        bus.count_enable = '1;
        n_rst = 1'b0;
        #2;
        check("rst_between_edges", cnt_of(0), 1);
        tick();
        check("rst_count0", cnt_of(0), 0);
        check("rst_wrap", int'(bus.wrap_pulse), 0);
        n_rst = 1'b1;
        bus.count_enable = '0;

        // Load 3 then count down saturating
        set_lval(0, 3);
        bus.load = 3'b001;
        tick();
        check("dnsat_load", cnt_of(0), 3);
        bus.load = '0;
        bus.count_down = 3'b001;
        bus.saturate = 3'b001;
        bus.count_enable = 3'b001;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("dnsat_seq", cnt_of(0), dn_seq[k]);
            check("dnsat_flag", int'(bus.rollover_flag[0]), int'(dn_seq[k] == 0));
            check("dnsat_pulse", int'(bus.wrap_pulse[0]), 0);
        end

        // Cascade channel 1 on channel 0, both wrapping at 3
        bus.count_enable = '0;
        bus.count_down = '0;
        bus.saturate = '0;
        bus.clear = '1;
        tick();
        bus.clear = '0;
        set_roll(0, 3);
        set_roll(1, 3);
        bus.cascade = 3'b010;
        bus.count_enable = 3'b011;
        wp1_count = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            check("casc_ch1", cnt_of(1), ((k + 1) / 4) % 4);
            if (bus.wrap_pulse[1]) wp1_count++;
        end
        check("casc_end0", cnt_of(0), 0);
        check("casc_end1", cnt_of(1), 0);
        check("casc_wp1_once", wp1_count, 1);
        bus.count_enable = '0;

        // Clear beats load beats step; then load beats step
        bus.clear = 3'b001;
        bus.load = 3'b001;
        set_lval(0, 9);
        bus.count_enable = 3'b001;
        tick();
        check("prio_clear", cnt_of(0), 0);
        bus.clear = '0;
        tick();
        check("prio_load", cnt_of(0), 9);
        bus.load = '0;

        // Count above a lowered rollover value
        bus.count_enable = '0;
        set_roll(0, 15);
        set_lval(0, 12);
        bus.load = 3'b001;
        tick();
        bus.load = '0;
        set_roll(0, 7);
        bus.count_enable = 3'b001;
        tick();
        check("bnd_up_wrap", cnt_of(0), 0);
        check("bnd_up_pulse", int'(bus.wrap_pulse[0]), 1);
        bus.count_enable = '0;
        bus.load = 3'b001;
        tick();
        bus.load = '0;
        bus.count_down = 3'b001;
        bus.count_enable = 3'b001;
        tick();
        check("bnd_down", cnt_of(0), 11);

        // Random traffic with occasional mode and terminal changes
        for (int k = 0; k < 400; k++) begin
            if (k % 25 == 0) begin
                bus.count_down   = N'($urandom);
                bus.saturate     = N'($urandom);
                bus.cascade      = N'($urandom);
                for (int i = 0; i < N; i++)
                    set_roll(i, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 15));
            end
            n_rst = ($urandom_range(0, 60) != 0);
            bus.count_enable = N'($urandom) | N'($urandom);
            for (int i = 0; i < N; i++) begin
                bus.clear[i] = ($urandom_range(0, 20) == 0);
                bus.load[i]  = ($urandom_range(0, 12) == 0);
                set_lval(i, $urandom_range(0, 15));
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
